// File: rtl/arp_resolver.sv
// ARP resolver: turns a next-hop IP lookup into ARP cache queries and
// who-has retries, answering with a MAC address or a failure.
module arp_resolver #(
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 125000000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,

  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,

  output logic        cache_query_request_valid,
  input  logic        cache_query_request_ready,
  output logic [31:0] cache_query_request_ip,

  input  logic        cache_query_response_valid,
  output logic        cache_query_response_ready,
  input  logic        cache_query_response_error,
  input  logic [47:0] cache_query_response_mac,

  output logic        arp_tx_valid,
  input  logic        arp_tx_ready,
  output logic [31:0] arp_tx_ip,

  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask
);

  localparam int TIMER_W = $clog2(RETRY_INTERVAL);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_QUERY      = 3'd1;
  localparam logic [2:0] S_WAIT_QUERY = 3'd2;
  localparam logic [2:0] S_SEND_ARP   = 3'd3;
  localparam logic [2:0] S_WAIT_RETRY = 3'd4;
  localparam logic [2:0] S_RESPOND    = 3'd5;

  localparam logic [3:0]         RETRIES_INIT = 4'(RETRY_COUNT);
  localparam logic [TIMER_W-1:0] TIMER_INIT   = TIMER_W'(RETRY_INTERVAL - 1);

  logic [2:0]         r_state;
  logic               r_arp_request_ready;
  logic [31:0]        r_lookup_ip;
  logic [3:0]         r_retries_left;
  logic [TIMER_W-1:0] r_timer;
  logic [47:0]        r_resp_mac;
  logic               r_resp_error;

  logic [2:0]         w_next_state;
  logic               w_accept;
  logic               w_is_broadcast;
  logic               w_no_local_ip;
  logic               w_on_subnet;

  assign w_accept       = arp_request_valid && r_arp_request_ready;
  assign w_is_broadcast = (arp_request_ip == 32'hFFFF_FFFF) ||
                          (arp_request_ip == (local_ip | ~subnet_mask));
  assign w_no_local_ip  = (local_ip == 32'h0);
  assign w_on_subnet    = (((arp_request_ip ^ local_ip) & subnet_mask) == 32'h0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_broadcast || w_no_local_ip) w_next_state = S_RESPOND;
          else                                 w_next_state = S_QUERY;
        end
      end
      S_QUERY: begin
        if (cache_query_request_ready) w_next_state = S_WAIT_QUERY;
      end
      S_WAIT_QUERY: begin
        // A miss with no ARP frames left to send ends the lookup as a failure.
        if (cache_query_response_valid) begin
          if (!cache_query_response_error || (r_retries_left == 4'd0))
            w_next_state = S_RESPOND;
          else
            w_next_state = S_SEND_ARP;
        end
      end
      S_SEND_ARP: begin
        if (arp_tx_ready) w_next_state = S_WAIT_RETRY;
      end
      S_WAIT_RETRY: begin
        if (r_timer == '0) w_next_state = S_QUERY;
      end
      S_RESPOND: begin
        if (arp_response_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= S_IDLE;
      r_arp_request_ready <= 1'b0;
      r_lookup_ip         <= 32'h0;
      r_retries_left      <= 4'd0;
      r_timer             <= '0;
      r_resp_mac          <= 48'h0;
      r_resp_error        <= 1'b0;
    end else begin
      r_state             <= w_next_state;
      r_arp_request_ready <= (w_next_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          // Config inputs are sampled only here, so they may change mid-lookup.
          if (w_accept) begin
            if (w_is_broadcast) begin
              r_resp_mac   <= 48'hFFFF_FFFF_FFFF;
              r_resp_error <= 1'b0;
            end else if (w_no_local_ip) begin
              r_resp_mac   <= 48'h0;
              r_resp_error <= 1'b1;
            end else begin
              r_lookup_ip    <= w_on_subnet ? arp_request_ip : gateway_ip;
              r_retries_left <= RETRIES_INIT;
            end
          end
        end
        S_WAIT_QUERY: begin
          if (cache_query_response_valid) begin
            if (!cache_query_response_error) begin
              r_resp_mac   <= cache_query_response_mac;
              r_resp_error <= 1'b0;
            end else if (r_retries_left == 4'd0) begin
              r_resp_mac   <= 48'h0;
              r_resp_error <= 1'b1;
            end
          end
        end
        S_SEND_ARP: begin
          if (arp_tx_ready) begin
            r_retries_left <= r_retries_left - 4'd1;
            r_timer        <= TIMER_INIT;
          end
        end
        S_WAIT_RETRY: begin
          if (r_timer != '0) r_timer <= r_timer - TIMER_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign arp_request_ready          = r_arp_request_ready;
  assign arp_response_valid         = (r_state == S_RESPOND);
  assign arp_response_error         = r_resp_error;
  assign arp_response_mac           = r_resp_mac;
  assign cache_query_request_valid  = (r_state == S_QUERY);
  assign cache_query_request_ip     = r_lookup_ip;
  assign cache_query_response_ready = (r_state == S_WAIT_QUERY);
  assign arp_tx_valid               = (r_state == S_SEND_ARP);
  assign arp_tx_ip                  = r_lookup_ip;

endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver: a vector table of single lookups plus
// hand-written stall and reset-during-retry sequences.
module tb_arp_resolver;

  logic        clk;
  logic        rst;
  logic        arp_request_valid;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip;
  logic        arp_response_valid;
  logic        arp_response_ready;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;
  logic        cache_query_request_valid;
  logic        cache_query_request_ready;
  logic [31:0] cache_query_request_ip;
  logic        cache_query_response_valid;
  logic        cache_query_response_ready;
  logic        cache_query_response_error;
  logic [47:0] cache_query_response_mac;
  logic        arp_tx_valid;
  logic        arp_tx_ready;
  logic [31:0] arp_tx_ip;
  logic [31:0] local_ip;
  logic [31:0] gateway_ip;
  logic [31:0] subnet_mask;

  arp_resolver #(
    .RETRY_COUNT(2),
    .RETRY_INTERVAL(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arp_request_valid(arp_request_valid),
    .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid),
    .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error),
    .arp_response_mac(arp_response_mac),
    .cache_query_request_valid(cache_query_request_valid),
    .cache_query_request_ready(cache_query_request_ready),
    .cache_query_request_ip(cache_query_request_ip),
    .cache_query_response_valid(cache_query_response_valid),
    .cache_query_response_ready(cache_query_response_ready),
    .cache_query_response_error(cache_query_response_error),
    .cache_query_response_mac(cache_query_response_mac),
    .arp_tx_valid(arp_tx_valid),
    .arp_tx_ready(arp_tx_ready),
    .arp_tx_ip(arp_tx_ip),
    .local_ip(local_ip),
    .gateway_ip(gateway_ip),
    .subnet_mask(subnet_mask)
  );

  typedef struct {
    logic [31:0] ip;
    logic [31:0] localIp;
    int          misses;
    logic [47:0] cacheMac;
    int          expQueries;
    int          expTx;
    logic [31:0] expQueryIp;
    logic [31:0] expTxIp;
    logic        expErr;
    logic [47:0] expMac;
    int          expLat;
  } vec_t;

  localparam int NUM_VECS = 7;
  vec_t vecs[NUM_VECS];

  int checkCount = 0;
  int passCount  = 0;

  int          cycNum = 0;
  int          queryCount = 0;
  int          txCount = 0;
  int          respCount = 0;
  int          reqHsCyc = 0;
  int          firstRespCyc = 0;
  int          lastTxCyc = 0;
  int          gapCount = 0;
  int          minGap = 1000000;
  int          maxGap = 0;
  bit          pendingTx = 0;
  bit          respPrev = 0;
  logic [31:0] lastQueryIp = 32'h0;
  logic [31:0] lastTxIp = 32'h0;
  logic [47:0] lastRespMac = 48'h0;
  logic        lastRespErr = 1'b0;

  int          hitAfter = 0;
  logic [47:0] cacheMac = 48'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observes every handshake at the clock edge and plays the ARP cache,
  // answering each query one cycle later; query numbers above hitAfter hit.
  initial begin : cacheAndMonitor
    bit qHs;
    bit rHs;
    int gap;
    cache_query_response_valid = 1'b0;
    cache_query_response_error = 1'b0;
    cache_query_response_mac   = 48'h0;
    forever begin
      @(posedge clk);
      cycNum++;
      qHs = (cache_query_request_valid && cache_query_request_ready);
      rHs = (cache_query_response_valid && cache_query_response_ready);
      if (rst) pendingTx = 0;
      if (arp_request_valid && arp_request_ready) reqHsCyc = cycNum;
      if (qHs) begin
        queryCount++;
        lastQueryIp = cache_query_request_ip;
        if (pendingTx) begin
          gap = cycNum - lastTxCyc;
          gapCount++;
          if (gap < minGap) minGap = gap;
          if (gap > maxGap) maxGap = gap;
          pendingTx = 0;
        end
      end
      if (arp_tx_valid && arp_tx_ready) begin
        txCount++;
        lastTxIp  = arp_tx_ip;
        lastTxCyc = cycNum;
        pendingTx = 1;
      end
      if (arp_response_valid && !respPrev) firstRespCyc = cycNum;
      respPrev = arp_response_valid;
      if (arp_response_valid && arp_response_ready) begin
        respCount++;
        lastRespMac = arp_response_mac;
        lastRespErr = arp_response_error;
      end
      #1;
      if (rst) begin
        cache_query_response_valid = 1'b0;
      end else begin
        if (rHs) cache_query_response_valid = 1'b0;
        if (qHs) begin
          cache_query_response_valid = 1'b1;
          cache_query_response_error = (queryCount > hitAfter) ? 1'b0 : 1'b1;
          cache_query_response_mac   = (queryCount > hitAfter) ? cacheMac : 48'hDEAD_BEEF_0000;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic sendRequest(input logic [31:0] ip, output bit ok);
    int n = 0;
    arp_request_ip    = ip;
    arp_request_valid = 1'b1;
    while (!arp_request_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = arp_request_ready;
    @(posedge clk); #1;
    arp_request_valid = 1'b0;
  endtask

  task automatic waitResponse(input int r0, output bit ok);
    int n = 0;
    while (respCount == r0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (respCount != r0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int  q0;
    int  t0;
    int  r0;
    bit  ok;
    local_ip = v.localIp;
    hitAfter = queryCount + v.misses;
    cacheMac = v.cacheMac;
    q0 = queryCount;
    t0 = txCount;
    r0 = respCount;
    sendRequest(v.ip, ok);
    checkOutput($sformatf("v%0d.accepted", idx), 64'(ok), 64'd1);
    waitResponse(r0, ok);
    checkOutput($sformatf("v%0d.responded", idx), 64'(ok), 64'd1);
    checkOutput($sformatf("v%0d.queries", idx), 64'(queryCount - q0), 64'(v.expQueries));
    checkOutput($sformatf("v%0d.arpTx", idx), 64'(txCount - t0), 64'(v.expTx));
    if (v.expQueries > 0)
      checkOutput($sformatf("v%0d.queryIp", idx), 64'(lastQueryIp), 64'(v.expQueryIp));
    if (v.expTx > 0)
      checkOutput($sformatf("v%0d.txIp", idx), 64'(lastTxIp), 64'(v.expTxIp));
    checkOutput($sformatf("v%0d.error", idx), 64'(lastRespErr), 64'(v.expErr));
    checkOutput($sformatf("v%0d.mac", idx), 64'(lastRespMac), 64'(v.expMac));
    if (v.expLat > 0)
      checkOutput($sformatf("v%0d.latency", idx), 64'(firstRespCyc - reqHsCyc), 64'(v.expLat));
  endtask

  initial begin : mainSeq
    bit          ok;
    int          q0;
    int          t0;
    int          r0;
    int          n;
    bit          stable;
    logic [31:0] captIp;
    logic [47:0] captMac;
    logic        captErr;
    vec_t        fresh;

    vecs[0] = '{32'hC0A80164, 32'hC0A80180, 0, 48'h5A5152535455, 1, 0, 32'hC0A80164, 32'h0, 1'b0, 48'h5A5152535455, 3};
    vecs[1] = '{32'h08080808, 32'hC0A80180, 0, 48'h001122334455, 1, 0, 32'hC0A80101, 32'h0, 1'b0, 48'h001122334455, 3};
    vecs[2] = '{32'hC0A801FF, 32'hC0A80180, 0, 48'h001122334455, 0, 0, 32'h0, 32'h0, 1'b0, 48'hFFFFFFFFFFFF, 1};
    vecs[3] = '{32'hFFFFFFFF, 32'hC0A80180, 0, 48'h001122334455, 0, 0, 32'h0, 32'h0, 1'b0, 48'hFFFFFFFFFFFF, 1};
    vecs[4] = '{32'hC0A80164, 32'hC0A80180, 99, 48'h001122334455, 3, 2, 32'hC0A80164, 32'hC0A80164, 1'b1, 48'h0, 0};
    vecs[5] = '{32'hC0A80164, 32'h00000000, 0, 48'h001122334455, 0, 0, 32'h0, 32'h0, 1'b1, 48'h0, 1};
    vecs[6] = '{32'hC0A80105, 32'hC0A80180, 0, 48'hAABBCCDDEEFF, 1, 0, 32'hC0A80105, 32'h0, 1'b0, 48'hAABBCCDDEEFF, 3};

    rst                       = 1'b1;
    arp_request_valid         = 1'b0;
    arp_request_ip            = 32'h0;
    arp_response_ready        = 1'b1;
    cache_query_request_ready = 1'b1;
    arp_tx_ready              = 1'b1;
    local_ip                  = 32'hC0A80180;
    gateway_ip                = 32'hC0A80101;
    subnet_mask               = 32'hFFFFFF00;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.reqReady", 64'(arp_request_ready), 64'd0);
    checkOutput("rst.respValid", 64'(arp_response_valid), 64'd0);
    checkOutput("rst.respError", 64'(arp_response_error), 64'd0);
    checkOutput("rst.respMac", 64'(arp_response_mac), 64'd0);
    checkOutput("rst.queryValid", 64'(cache_query_request_valid), 64'd0);
    checkOutput("rst.cacheRespReady", 64'(cache_query_response_ready), 64'd0);
    checkOutput("rst.txValid", 64'(arp_tx_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst.readyAfter", 64'(arp_request_ready), 64'd1);

    for (int i = 0; i < NUM_VECS; i++) applyStimulus(i, vecs[i]);

    // Miss then hit, with the ARP generator and the consumer both stalling.
    $display("[TB] stall sequence");
    local_ip           = 32'hC0A80180;
    hitAfter           = queryCount + 1;
    cacheMac           = 48'h0123456789AB;
    arp_tx_ready       = 1'b0;
    arp_response_ready = 1'b0;
    q0 = queryCount;
    t0 = txCount;
    r0 = respCount;
    sendRequest(32'hC0A80164, ok);
    checkOutput("stall.accepted", 64'(ok), 64'd1);
    n = 0;
    while (!arp_tx_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("stall.txValid", 64'(arp_tx_valid), 64'd1);
    captIp = arp_tx_ip;
    stable = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!(arp_tx_valid === 1'b1 && arp_tx_ip === captIp)) stable = 0;
    end
    checkOutput("stall.txStable", 64'(stable), 64'd1);
    checkOutput("stall.txIp", 64'(captIp), 64'hC0A80164);
    arp_tx_ready = 1'b1;
    n = 0;
    while (!arp_response_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("stall.respValid", 64'(arp_response_valid), 64'd1);
    captMac = arp_response_mac;
    captErr = arp_response_error;
    stable  = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!(arp_response_valid === 1'b1 && arp_response_mac === captMac &&
            arp_response_error === captErr)) stable = 0;
    end
    checkOutput("stall.respStable", 64'(stable), 64'd1);
    arp_response_ready = 1'b1;
    waitResponse(r0, ok);
    checkOutput("stall.responded", 64'(ok), 64'd1);
    checkOutput("stall.queries", 64'(queryCount - q0), 64'd2);
    checkOutput("stall.arpTx", 64'(txCount - t0), 64'd1);
    checkOutput("stall.error", 64'(lastRespErr), 64'd0);
    checkOutput("stall.mac", 64'(lastRespMac), 64'h0123456789AB);

    // Reset while waiting between retries abandons the lookup cleanly.
    $display("[TB] reset during retry wait");
    hitAfter = queryCount + 99;
    t0 = txCount;
    r0 = respCount;
    sendRequest(32'hC0A80164, ok);
    checkOutput("rstRetry.accepted", 64'(ok), 64'd1);
    n = 0;
    while (txCount == t0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rstRetry.firstTx", 64'(txCount - t0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstRetry.queryValid", 64'(cache_query_request_valid), 64'd0);
    checkOutput("rstRetry.txValid", 64'(arp_tx_valid), 64'd0);
    checkOutput("rstRetry.respValid", 64'(arp_response_valid), 64'd0);
    checkOutput("rstRetry.reqReady", 64'(arp_request_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    t0 = txCount;
    q0 = queryCount;
    @(posedge clk); #1;
    checkOutput("rstRetry.readyAfter", 64'(arp_request_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("rstRetry.noMoreTx", 64'(txCount - t0), 64'd0);
    checkOutput("rstRetry.noMoreQuery", 64'(queryCount - q0), 64'd0);
    checkOutput("rstRetry.noResponse", 64'(respCount - r0), 64'd0);

    fresh = '{32'hC0A80164, 32'hC0A80180, 99, 48'h001122334455, 3, 2, 32'hC0A80164, 32'hC0A80164, 1'b1, 48'h0, 0};
    applyStimulus(100, fresh);

    checkOutput("retry.gapsSeen", 64'(gapCount > 0), 64'd1);
    checkOutput("retry.minGap", 64'(minGap), 64'd17);
    checkOutput("retry.maxGap", 64'(maxGap), 64'd17);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
